// File: rtl/vending_machine_param_if.sv
// Signal bundle between the coin-acceptor pulse logic and the dispense/change actuators.
interface vending_machine_param_if #(
  parameter int CREDIT_W = 4
) ();
  logic                coin1;
  logic                coin2;
  logic                cancel;
  logic                restock;
  logic                vend;
  logic                change_out;
  logic                busy;
  logic [CREDIT_W-1:0] credit;
  logic                sold_out;

  modport master (
    output coin1, coin2, cancel, restock,
    input  vend, change_out, busy, credit, sold_out
  );

  modport slave (
    input  coin1, coin2, cancel, restock,
    output vend, change_out, busy, credit, sold_out
  );
endinterface

// File: rtl/vending_machine_param.sv
// Parametrised vending FSM: coin credit, one-cycle vend pulse, serial change/refund.
// Optional stock counter and sold-out refund enabled by defining INVENTORY_EN.
module vending_machine_param #(
  parameter int CREDIT_W   = 4,
  parameter int PRICE      = 3,
  parameter int COIN1_VAL  = 1,
  parameter int COIN2_VAL  = 2,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  vending_machine_param_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VEND    = 2'd2,
    S_CHANGE  = 2'd3
  } state_t;

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] COIN1_C = CREDIT_W'(COIN1_VAL);
  localparam logic [CREDIT_W-1:0] COIN2_C = CREDIT_W'(COIN2_VAL);
  localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] ZERO_C  = {CREDIT_W{1'b0}};

  // The accumulator must hold the largest credit reachable just below PRICE plus both coins.
  generate
    if ((PRICE < 1) || (PRICE > (2**CREDIT_W) - 1)) begin : g_bad_price
      $error("vending_machine_param: PRICE out of range 1..2^CREDIT_W-1");
    end
    if ((PRICE - 1 + COIN1_VAL + COIN2_VAL) > ((2**CREDIT_W) - 1)) begin : g_bad_width
      $error("vending_machine_param: PRICE-1+COIN1_VAL+COIN2_VAL exceeds credit range");
    end
  endgenerate

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] coin_add_s, sum_s;
  logic                coin_s, refund_s, sold_out_s;
  logic                vend_q, change_q, busy_q;

`ifdef INVENTORY_EN
  localparam logic [STOCK_W-1:0] STOCK_INIT_C = STOCK_W'(STOCK_INIT);
  localparam logic [STOCK_W-1:0] STOCK_ONE_C  = STOCK_W'(1);
  localparam logic [STOCK_W-1:0] STOCK_ZERO_C = {STOCK_W{1'b0}};

  logic [STOCK_W-1:0] stock_q, stock_d;
  logic               sold_out_q;

  assign sold_out_s   = sold_out_q;
  assign bus.sold_out = sold_out_q;

  // Stock next-state: restock wins over the decrement on VEND exit.
  always_comb begin
    stock_d = stock_q;
    if (bus.restock) begin
      stock_d = STOCK_INIT_C;
    end else if ((state_q == S_VEND) && (stock_q != STOCK_ZERO_C)) begin
      stock_d = stock_q - STOCK_ONE_C;
    end else begin
      stock_d = stock_q;
    end
  end

  // Stock counter and registered sold-out flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stock_q    <= STOCK_INIT_C;
      sold_out_q <= (STOCK_INIT_C == STOCK_ZERO_C);
    end else begin
      stock_q    <= stock_d;
      sold_out_q <= (stock_d == STOCK_ZERO_C);
    end
  end
`else
  logic unused_restock_s;

  assign unused_restock_s = bus.restock;
  assign sold_out_s       = 1'b0;
  assign bus.sold_out     = 1'b0;
`endif

  assign coin_s     = bus.coin1 | bus.coin2;
  assign coin_add_s = (bus.coin1 ? COIN1_C : ZERO_C) + (bus.coin2 ? COIN2_C : ZERO_C);
  assign sum_s      = credit_q + coin_add_s;
  // Cancel, or any coin while sold out, turns the whole sum into change.
  assign refund_s   = bus.cancel | (sold_out_s & coin_s);

  // Next-state and credit update.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (refund_s && (sum_s != ZERO_C)) begin
          credit_d = sum_s;
          state_d  = S_CHANGE;
        end else if (sum_s >= PRICE_C) begin
          credit_d = sum_s;
          state_d  = S_VEND;
        end else if (sum_s != ZERO_C) begin
          credit_d = sum_s;
          state_d  = S_COLLECT;
        end else begin
          credit_d = credit_q;
          state_d  = state_q;
        end
      end
      S_VEND: begin
        credit_d = credit_q - PRICE_C;
        if (credit_q != PRICE_C) begin
          state_d = S_CHANGE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHANGE: begin
        if (credit_q <= ONE_C) begin
          credit_d = ZERO_C;
          state_d  = S_IDLE;
        end else begin
          credit_d = credit_q - ONE_C;
          state_d  = S_CHANGE;
        end
      end
      default: begin
        credit_d = ZERO_C;
        state_d  = S_IDLE;
      end
    endcase
  end

  // State/credit registers; outputs registered from the next state so they track it cycle-exact.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      credit_q <= ZERO_C;
      vend_q   <= 1'b0;
      change_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      vend_q   <= (state_d == S_VEND);
      change_q <= (state_d == S_CHANGE);
      busy_q   <= (state_d == S_VEND) || (state_d == S_CHANGE);
    end
  end

  assign bus.vend       = vend_q;
  assign bus.change_out = change_q;
  assign bus.busy       = busy_q;
  assign bus.credit     = credit_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// Self-checking bench for vending_machine_param: directed plan steps then random traffic
// compared against a transaction-level model (scheduled vend/change cycles in a queue).
module tb_vending_machine_param;

  localparam int CREDIT_W  = 4;
  localparam int PRICE     = 3;
  localparam int COIN1_VAL = 1;
  localparam int COIN2_VAL = 2;
  localparam int STOCK_W   = 4;
`ifdef INVENTORY_EN
  localparam int STOCK_INIT = 1;
`else
  localparam int STOCK_INIT = 8;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  string phase = "init";

  vending_machine_param_if #(.CREDIT_W(CREDIT_W)) bus ();

  vending_machine_param #(
    .CREDIT_W  (CREDIT_W),
    .PRICE     (PRICE),
    .COIN1_VAL (COIN1_VAL),
    .COIN2_VAL (COIN2_VAL),
    .STOCK_W   (STOCK_W),
    .STOCK_INIT(STOCK_INIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Model: outputs of the current cycle plus a queue of already-scheduled future cycles.
  typedef struct packed {
    logic                vend;
    logic                chg;
    logic [CREDIT_W-1:0] credit;
  } cyc_t;

  cyc_t cur;
  cyc_t pend[$];
  int   stock;

  function automatic cyc_t mk(input logic v, input logic c, input int cr);
    cyc_t r;
    r.vend   = v;
    r.chg    = c;
    r.credit = cr[CREDIT_W-1:0];
    return r;
  endfunction

  function automatic logic model_sold();
`ifdef INVENTORY_EN
    return (stock == 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    cur = mk(1'b0, 1'b0, 0);
    pend.delete();
    stock = STOCK_INIT;
  endtask

  task automatic model_edge(input logic c1, input logic c2, input logic cn, input logic rs);
    int   sum;
    logic was_vend;
    logic sold;
    was_vend = cur.vend;
    sold     = model_sold();
    if (cur.vend || cur.chg) begin
      if (pend.size() > 0) cur = pend.pop_front();
      else                 cur = mk(1'b0, 1'b0, 0);
    end else begin
      sum = int'(cur.credit) + (c1 ? COIN1_VAL : 0) + (c2 ? COIN2_VAL : 0);
      if ((sum > 0) && (cn || (sold && (c1 || c2)))) begin
        for (int k = sum; k >= 1; k--) pend.push_back(mk(1'b0, 1'b1, k));
        cur = pend.pop_front();
      end else if (sum >= PRICE) begin
        cur = mk(1'b1, 1'b0, sum);
        for (int k = sum - PRICE; k >= 1; k--) pend.push_back(mk(1'b0, 1'b1, k));
      end else begin
        cur = mk(1'b0, 1'b0, sum);
      end
    end
`ifdef INVENTORY_EN
    if (rs)            stock = STOCK_INIT;
    else if (was_vend) stock = stock - 1;
`endif
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk({phase, "_vend"},     32'(bus.vend),       32'(cur.vend));
    chk({phase, "_change"},   32'(bus.change_out), 32'(cur.chg));
    chk({phase, "_busy"},     32'(bus.busy),       32'(cur.vend | cur.chg));
    chk({phase, "_credit"},   32'(bus.credit),     32'(cur.credit));
    chk({phase, "_sold_out"}, 32'(bus.sold_out),   32'(model_sold()));
  endtask

  task automatic step(input logic c1, input logic c2, input logic cn, input logic rs);
    bus.coin1   = c1;
    bus.coin2   = c2;
    bus.cancel  = cn;
    bus.restock = rs;
    @(posedge clk);
    model_edge(c1, c2, cn, rs);
    @(negedge clk);
    bus.coin1   = 1'b0;
    bus.coin2   = 1'b0;
    bus.cancel  = 1'b0;
    bus.restock = 1'b0;
    check_all();
  endtask

  task automatic async_reset_now();
    #2 rst = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    check_all();
    rst = 1'b1;
  endtask

  initial begin
    bus.coin1   = 1'b0;
    bus.coin2   = 1'b0;
    bus.cancel  = 1'b0;
    bus.restock = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    phase = "reset";
    check_all();
    rst = 1'b1;

    phase = "t1_three_coin1";
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_credit_after_1", 32'(bus.credit), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_credit_after_2", 32'(bus.credit), 32'd2);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_vend_pulse", 32'(bus.vend), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_vend_single", 32'(bus.vend), 32'd0);
    chk("t1_no_change", 32'(bus.change_out), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    phase = "t2_two_coin2";
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t2_credit_4", 32'(bus.credit), 32'd4);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_one_change", 32'(bus.change_out), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_idle_busy", 32'(bus.busy), 32'd0);

    phase = "t3_both_coins";
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t3_credit_3", 32'(bus.credit), 32'd3);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_coin_ignored", 32'(bus.credit), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    phase = "t4_cancel";
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("t4_refund_credit", 32'(bus.credit), 32'd2);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    phase = "t5_async_reset";
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_in_change", 32'(bus.change_out), 32'd1);
    async_reset_now();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

`ifdef INVENTORY_EN
    phase = "inv";
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("inv_sold_out", 32'(bus.sold_out), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("inv_refund_no_vend", 32'(bus.vend), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("inv_restocked", 32'(bus.sold_out), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("inv_vend_after_restock", 32'(bus.vend), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
`endif

    phase = "random";
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        async_reset_now();
      end else begin
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vending_machine_param.md
Name: vending_machine_param

Overview:
- Parametrised successor to the team's two-coin vending FSM. Adds configurable coin values, price and credit width, a cancel/refund path, and serialised change return.
- Accumulates coin credit and issues a one-cycle vend pulse once credit reaches PRICE. Returns any excess or refunded credit one unit per cycle.
- Sits between the coin-acceptor pulse logic and the dispense/change actuators.

Parameters:
- CREDIT_W, 4, width of the credit accumulator.
- PRICE, 3, item price in credit units, 1..2^CREDIT_W-1.
- COIN1_VAL, 1, credit units added by coin1.
- COIN2_VAL, 2, credit units added by coin2.
- STOCK_W, 4, width of the stock counter. Used only with INVENTORY_EN.
- STOCK_INIT, 8, stock loaded at reset and on restock. Used only with INVENTORY_EN.
- Legality: PRICE-1+COIN1_VAL+COIN2_VAL must be ≤ 2^CREDIT_W-1. Violation triggers an elaboration-time $error.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset. Asserted (0) forces reset state immediately.
- coin1  input  1  single-cycle pulse, one coin of value COIN1_VAL.
- coin2  input  1  single-cycle pulse, one coin of value COIN2_VAL.
- cancel  input  1  single-cycle pulse requesting refund of the current credit.
- restock  input  1  single-cycle pulse reloading stock. Ignored without INVENTORY_EN.
- vend  output  1  one-cycle dispense pulse.
- change_out  output  1  one pulse per returned credit unit.
- busy  output  1  high in VEND/CHANGE; coins ignored while high.
- credit  output  CREDIT_W  current credit.
- sold_out  output  1  stock exhausted. Constant 0 without INVENTORY_EN.

Behaviour:
- Outputs: all are decoded from registered state/credit only (Moore); there is no input-to-output combinational path.
- Reset (rst=0, async): state=IDLE, credit=0, vend=0, change_out=0, busy=0, stock=STOCK_INIT, sold_out=0. Reset mid-operation discards credit and any pending change.
- States: IDLE (credit 0), COLLECT (0 < credit < PRICE), VEND, CHANGE.
- IDLE/COLLECT, edge with coins: sum = credit + coin1·COIN1_VAL + coin2·COIN2_VAL.
  - Simultaneous coin1 and coin2 are both counted.
  - If cancel is also high: credit ← sum, next=CHANGE if sum>0, else IDLE. Cancel beats vend.
  - Else if sum ≥ PRICE: credit ← sum, next=VEND.
  - Else if sum > 0: credit ← sum, next=COLLECT.
  - Else: stay.
- Cancel with credit=0 and no coin: no effect.
- VEND: vend=1 for exactly this cycle. Next edge: credit ← credit−PRICE; next=CHANGE if the result >0, else IDLE.
- CHANGE: change_out=1 each cycle. Each edge decrements credit by 1; credit 1→0 moves to IDLE.
  - Change pulse count equals the credit on entry.
- Coins and cancel arriving in VEND/CHANGE are ignored and lost; upstream must not issue them while busy=1.
- Latency: the coin completing the price is sampled at edge n → vend=1 in cycle n+1 → first change_out in cycle n+2.
- busy = (state==VEND) | (state==CHANGE).
- Arithmetic: unsigned, CREDIT_W bits. The legality rule makes overflow impossible, so no saturation logic is required.

Optional Feature:
INVENTORY_EN
- Defined: a STOCK_W-bit stock counter decrements on each VEND-state exit. sold_out=1 when stock==0.
  - While sold_out, any coin edge in IDLE/COLLECT routes credit+coins to CHANGE (full refund); VEND is never entered.
  - restock (sampled in any state) reloads STOCK_INIT and clears sold_out next cycle.
  - restock has priority over a same-cycle decrement.
- Undefined: no stock counter; restock is ignored, sold_out tied to 0, and vending is unlimited.

Test Plan:
- Defaults; coin1 on three separate cycles → credit 1,2,3; vend=1 for one cycle after third coin; no change_out; back to IDLE with credit 0.
- coin2, then coin2 → credit 4, vend pulse, then exactly one change_out pulse; busy high for 2 cycles; IDLE.
- coin1 and coin2 in the same cycle → credit 3, vend next cycle, zero change; coin1 pulse during the vend cycle is ignored (credit returns to 0).
- coin1, then cancel together with coin1 → credit 2, no vend, two change_out pulses, IDLE.
- coin2, coin2, then assert rst=0 during the CHANGE cycle → all outputs 0 immediately, credit 0, IDLE after release; no further change_out.
- INVENTORY_EN with STOCK_INIT=1:
  - Vend once → sold_out=1.
  - Then coin2 → no vend, two change_out pulses.
  - restock → sold_out=0; coin2+coin1 → vend.
